vga_timing_gen: RTL and testbench

//  Source end of the DrawX/DrawY/blank pixel interface consumed by the screen/sprite mappers.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_timing_gen_sync_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants and the coordinate/frame-counter types
// shared by the timing generator and its consumers.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync pulse windows are half-open: [START, END)
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Mapper pipeline alignment: ROM read for blank, ROM + RGB register for sync
  localparam int unsigned DEF_BLANK_DELAY = 1;
  localparam int unsigned DEF_SYNC_DELAY  = 2;

  typedef logic [9:0]  coord_t;
  typedef logic [15:0] frame_cnt_t;

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Async-reset shift register used to re-time video control signals.
// DEPTH of 0 degenerates to a wire from an already-registered source.
module sync_delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator: counters, active/sync decodes and line/frame
// pulses, with blank and sync re-timed to the mapper pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned BLANK_DELAY = DEF_BLANK_DELAY,
  parameter int unsigned SYNC_DELAY  = DEF_SYNC_DELAY
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_W = $clog2(H_TOTAL);
  localparam int unsigned V_W = $clog2(V_TOTAL);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: raster totals do not fit 10-bit coordinates");
  end
  if (BLANK_DELAY > 7 || SYNC_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: delay line depth limited to 7");
  end

  logic [H_W-1:0] hc, hc_next;
  logic [V_W-1:0] vc, vc_next;
  frame_cnt_t     frame_cnt, frame_cnt_next;
  logic           run;
  logic           eol, eof;
  logic           act_next, hs_next, vs_next;
  logic           act_r, hs_r, vs_r;
  logic [1:0]     sync_d;

  // Next raster position; the first edge out of reset holds (0,0) so that
  // cycle presents origin with frame_start high.
  always_comb begin
    eol            = (hc == H_W'(H_TOTAL - 1));
    eof            = eol && (vc == V_W'(V_TOTAL - 1));
    hc_next        = '0;
    vc_next        = '0;
    frame_cnt_next = frame_cnt;
    if (run) begin
      hc_next = eol ? '0 : hc + H_W'(1);
      vc_next = eof ? '0 : (eol ? vc + V_W'(1) : vc);
      if (eof) frame_cnt_next = frame_cnt + 16'd1;
    end
    act_next = (hc_next < H_W'(H_ACTIVE)) && (vc_next < V_W'(V_ACTIVE));
    hs_next  = !((hc_next >= H_W'(H_SYNC_START)) && (hc_next < H_W'(H_SYNC_END)));
    vs_next  = !((vc_next >= V_W'(V_SYNC_START)) && (vc_next < V_W'(V_SYNC_END)));
  end

  // Decodes are registered alongside the counters so they stay aligned with DrawX/DrawY
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run         <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      frame_cnt   <= '0;
      act_r       <= 1'b0;
      hs_r        <= 1'b1;
      vs_r        <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      run         <= 1'b1;
      hc          <= hc_next;
      vc          <= vc_next;
      frame_cnt   <= frame_cnt_next;
      act_r       <= act_next;
      hs_r        <= hs_next;
      vs_r        <= vs_next;
      line_start  <= (hc_next == '0);
      frame_start <= (hc_next == '0) && (vc_next == '0);
    end
  end

  assign DrawX       = coord_t'(hc);
  assign DrawY       = coord_t'(vc);
  assign frame_count = frame_cnt;

  sync_delay_line #(
    .WIDTH     (1),
    .DEPTH     (BLANK_DELAY),
    .RESET_VAL (1'b0)
  ) u_blank_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   (act_r),
    .dout  (blank)
  );

  sync_delay_line #(
    .WIDTH     (2),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (2'b11)
  ) u_sync_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   ({hs_r, vs_r}),
    .dout  (sync_d)
  );

  assign hs = sync_d[1];
  assign vs = sync_d[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: reset values, line/frame timing, delayed
// blank/sync alignment, async mid-frame reset and frame counter wrap.
module tb_vga_timing_gen;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, hs, vs, line_start, frame_start;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_pass   = 0;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic act_f(input int h, input int v);
    return (h < 640) && (v < 480);
  endfunction

  function automatic logic hs_f(input int h);
    return !((h >= 656) && (h < 752));
  endfunction

  function automatic logic vs_f(input int v);
    return !((v >= 490) && (v < 492));
  endfunction

  // Walk n cycles from expected position (h0,v0); history before the window
  // is the reset state when from_reset is set, otherwise unknown and skipped.
  task automatic run_check(input int h0, input int v0, input int n, input bit from_reset);
    int h = h0;
    int v = v0;
    int ph1 = 0, pv1 = 0, ph2 = 0, pv2 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clk);
      check($sformatf("DrawX@%0d", i), 32'(DrawX), h);
      check($sformatf("DrawY@%0d", i), 32'(DrawY), v);
      check($sformatf("line_start@%0d", i), 32'(line_start), 32'(h == 0));
      check($sformatf("frame_start@%0d", i), 32'(frame_start), 32'(h == 0 && v == 0));
      if (i >= 1)
        check($sformatf("blank@%0d", i), 32'(blank), 32'(act_f(ph1, pv1)));
      else if (from_reset)
        check($sformatf("blank@%0d", i), 32'(blank), 0);
      if (i >= 2) begin
        check($sformatf("hs@%0d", i), 32'(hs), 32'(hs_f(ph2)));
        check($sformatf("vs@%0d", i), 32'(vs), 32'(vs_f(pv2)));
      end else if (from_reset) begin
        check($sformatf("hs@%0d", i), 32'(hs), 1);
        check($sformatf("vs@%0d", i), 32'(vs), 1);
      end
      ph2 = ph1; pv2 = pv1;
      ph1 = h;   pv1 = v;
      if (h == 799) begin
        h = 0;
        v = (v == 524) ? 0 : v + 1;
      end else begin
        h = h + 1;
      end
    end
  endtask

  // Teleport the raster counters; the next edge advances from (h,v)
  task automatic jump_to(input int h, input int v);
    @(negedge vga_clk);
    force dut.hc = 10'(h);
    force dut.vc = 10'(v);
    #1;
    release dut.hc;
    release dut.vc;
  endtask

  task automatic wait_at(input int h, input int v, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge vga_clk);
      if (DrawX == 10'(h) && DrawY == 10'(v)) hit = 1'b1;
    end
    check($sformatf("reach_%0d_%0d", h, v), 32'(hit), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_DrawX"}, 32'(DrawX), 0);
    check({tag, "_DrawY"}, 32'(DrawY), 0);
    check({tag, "_blank"}, 32'(blank), 0);
    check({tag, "_hs"}, 32'(hs), 1);
    check({tag, "_vs"}, 32'(vs), 1);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
    check({tag, "_line_start"}, 32'(line_start), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vs_low;
    int vs_first;

    // Reset held for 5 cycles
    reset_n = 1'b0;
    repeat (5) @(negedge vga_clk);
    check_reset_outputs("rst");

    // First line and a bit of the second, from release
    reset_n = 1'b1;
    @(posedge vga_clk);
    run_check(0, 0, 1700, 1'b1);
    check("fc_after_lines", 32'(frame_count), 0);

    // End of line 0 and end of frame
    jump_to(795, 0);
    wait_at(799, 0, 10);
    @(negedge vga_clk);
    check("eol_DrawX", 32'(DrawX), 0);
    check("eol_DrawY", 32'(DrawY), 1);
    check("eol_line_start", 32'(line_start), 1);
    check("eol_frame_start", 32'(frame_start), 0);

    jump_to(795, 524);
    wait_at(799, 524, 10);
    check("eof_pre_fc", 32'(frame_count), 0);
    check("eof_pre_fs", 32'(frame_start), 0);
    @(negedge vga_clk);
    check("eof_DrawX", 32'(DrawX), 0);
    check("eof_DrawY", 32'(DrawY), 0);
    check("eof_fc", 32'(frame_count), 1);
    check("eof_fs", 32'(frame_start), 1);
    @(negedge vga_clk);
    check("eof_fs_pulse", 32'(frame_start), 0);
    check("eof_fc_hold", 32'(frame_count), 1);
    check("eof_DrawX_next", 32'(DrawX), 1);

    // Vertical blanking entry
    jump_to(795, 479);
    run_check(796, 479, 1620, 1'b0);

    // vs window: (0,490) is index 4, so vs drops at index 6 for 1600 cycles
    jump_to(795, 489);
    vs_low   = 0;
    vs_first = -1;
    for (int i = 0; i < 2420; i++) begin
      @(negedge vga_clk);
      if (!vs) begin
        vs_low++;
        if (vs_first < 0) vs_first = i;
      end
    end
    check("vs_low_cycles", vs_low, 1600);
    check("vs_first_low", vs_first, 6);

    // Last blanked line and wrap into a new frame
    jump_to(795, 523);
    run_check(796, 523, 820, 1'b0);
    check("fc_second_frame", 32'(frame_count), 2);

    // Async reset mid-frame at (300,200)
    jump_to(290, 200);
    wait_at(300, 200, 20);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (3) @(negedge vga_clk);
    check_reset_outputs("async_hold");
    reset_n = 1'b1;
    @(posedge vga_clk);
    run_check(0, 0, 1700, 1'b1);
    check("fc_after_async", 32'(frame_count), 0);

    // Frame counter wrap
    @(negedge vga_clk);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    check("wrap_preset", 32'(frame_count), 32'h0000_FFFF);
    jump_to(795, 524);
    wait_at(799, 524, 10);
    check("wrap_pre", 32'(frame_count), 32'h0000_FFFF);
    @(negedge vga_clk);
    check("wrap_fc", 32'(frame_count), 0);
    check("wrap_DrawX", 32'(DrawX), 0);
    check("wrap_DrawY", 32'(DrawY), 0);
    check("wrap_fs", 32'(frame_start), 1);
    @(negedge vga_clk);
    check("wrap_fs_pulse", 32'(frame_start), 0);
    check("wrap_fc_hold", 32'(frame_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
